// File: rtl/count_arbiter_ctrl_pkg.sv
// Shared types and constants for the count arbiter controller and its counter core.
package count_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : count_arbiter_ctrl_pkg

// File: rtl/count_arbiter_ctrl_count_core.sv
// Mod-MOD up/down counter; zero flag is registered on the same edge as value.
module count_core
    import count_arbiter_ctrl_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] value,
    output logic         zero
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] value_q, value_d;
    logic         zero_q, zero_d;

    always_comb begin
        value_d = value_q;
        if (en) begin
            if (up == DIR_UP) begin
                value_d = (value_q == MAX_VAL) ? '0 : value_q + W'(1);
            end else begin
                value_d = (value_q == '0) ? MAX_VAL : value_q - W'(1);
            end
        end
        zero_d = (value_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            value_q <= value_d;
            zero_q  <= zero_d;
        end
    end

    assign value = value_q;
    assign zero  = zero_q;

endmodule : count_core

// File: rtl/count_arbiter_ctrl.sv
// Round-robin arbiter for two requesters sharing one counter; an FSM steps the counter
// LEN times per grant. States: IDLE = wait for req | RUN = one step per cycle | DONE = completion pulse.
module count_arbiter_ctrl
    import count_arbiter_ctrl_pkg::*;
#(
    parameter int MOD   = 10,
    parameter int W     = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             abort,
    output logic [1:0]       ack,
    output logic [1:0]       done,
    output logic             aborted,
    output logic             busy,
    output logic             owner,
    output logic [W-1:0]     value,
    output logic             zero
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
    logic             aborted_q, aborted_d;
    logic [1:0]       ack_q, ack_d;

    logic             winner;
    logic             win_dir;
    logic [LEN_W-1:0] win_len;
    logic             step_en;

    // Favoured requester wins when asking; otherwise the other one, which must be asking.
    assign winner  = req[rr_q] ? rr_q : ~rr_q;
    assign win_dir = winner ? dir1 : dir0;
    assign win_len = winner ? len1 : len0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (remaining_q == LEN_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        remaining_d = remaining_q;
        dir_d       = dir_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        aborted_d   = aborted_q;
        ack_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d        = winner;
                    dir_d          = win_dir;
                    remaining_d    = win_len;
                    aborted_d      = 1'b0;
                    ack_d[winner]  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    remaining_d = remaining_q - LEN_W'(1);
                end
            end
            ST_DONE: rr_d = ~owner_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            dir_q       <= DIR_DOWN;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            aborted_q   <= 1'b0;
            ack_q       <= '0;
        end else begin
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            aborted_q   <= aborted_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        done    = '0;
        busy    = (state_q != ST_IDLE);
        aborted = (state_q == ST_DONE) && aborted_q;
        step_en = (state_q == ST_RUN) && !abort;
        if (state_q == ST_DONE) begin
            done[owner_q] = 1'b1;
        end
    end

    assign ack   = ack_q;
    assign owner = owner_q;

    count_core #(
        .MOD (MOD),
        .W   (W)
    ) u_count_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step_en),
        .up    (dir_q),
        .value (value),
        .zero  (zero)
    );

endmodule : count_arbiter_ctrl
